// File: rtl/csat_sweep_controller.sv
// csat_sweep_controller
// Exhaustive-search sequencer for a flattened combinational CSAT benchmark.
// Walks candidate assignments in ascending binary order, holds each one for
// SETTLE_CYCLES before sampling sat_i, stops on the first satisfying model and
// can resume from the next candidate to enumerate further models.

module csat_sweep_controller #(
  parameter int N_VARS        = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              resume_i,
  input  logic              abort_i,
  output logic [N_VARS-1:0] assign_o,
  input  logic              sat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic [N_VARS-1:0] model_o,
  output logic [N_VARS:0]   tried_o
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_LOAD   = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [N_VARS-1:0] ASSIGN_ONE = N_VARS'(1);
  localparam logic [N_VARS:0]   TRIED_ONE  = (N_VARS + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [N_VARS-1:0]   r_assign;
  logic [N_VARS-1:0]   w_nextAssign;
  logic [N_VARS-1:0]   r_model;
  logic [N_VARS-1:0]   w_nextModel;
  logic [N_VARS:0]     r_tried;
  logic [N_VARS:0]     w_nextTried;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_nextCnt;
  logic                r_done;
  logic                w_nextDone;
  logic                w_allOnes;
  logic                w_doStart;

  // The all-ones test guards every increment so the assignment never wraps.
  assign w_allOnes = (r_assign == '1);

  // start_i is honoured only when no sweep is running and abort_i is not present.
  assign w_doStart = start_i && !abort_i &&
                     ((r_state == IDLE) || (r_state == FOUND) || (r_state == EXHAUSTED));

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_assign <= '0;
      r_model  <= '0;
      r_tried  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_assign <= w_nextAssign;
      r_model  <= w_nextModel;
      r_tried  <= w_nextTried;
      r_cnt    <= w_nextCnt;
      r_done   <= w_nextDone;
    end
  end

  // Next-state and datapath updates; abort wins, then start, then resume.
  always_comb begin
    w_nextState  = r_state;
    w_nextAssign = r_assign;
    w_nextModel  = r_model;
    w_nextTried  = r_tried;
    w_nextCnt    = r_cnt;
    w_nextDone   = 1'b0;

    if (abort_i) begin
      w_nextState = IDLE;
    end else if (w_doStart) begin
      w_nextState  = SETTLE;
      w_nextAssign = '0;
      w_nextModel  = '0;
      w_nextTried  = '0;
      w_nextCnt    = CNT_LOAD;
    end else begin
      case (r_state)
        IDLE: begin
          w_nextState = IDLE;
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            w_nextState = CHECK;
          end else begin
            w_nextCnt = r_cnt - CNT_ONE;
          end
        end
        CHECK: begin
          w_nextTried = r_tried + TRIED_ONE;
          if (sat_i) begin
            w_nextState = FOUND;
            w_nextModel = r_assign;
            w_nextDone  = 1'b1;
          end else if (w_allOnes) begin
            w_nextState = EXHAUSTED;
            w_nextDone  = 1'b1;
          end else begin
            w_nextState  = SETTLE;
            w_nextAssign = r_assign + ASSIGN_ONE;
            w_nextCnt    = CNT_LOAD;
          end
        end
        FOUND: begin
          if (resume_i) begin
            if (w_allOnes) begin
              w_nextState = EXHAUSTED;
              w_nextDone  = 1'b1;
            end else begin
              w_nextState  = SETTLE;
              w_nextAssign = r_assign + ASSIGN_ONE;
              w_nextCnt    = CNT_LOAD;
            end
          end
        end
        EXHAUSTED: begin
          w_nextState = EXHAUSTED;
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  assign assign_o = r_assign;
  assign model_o  = r_model;
  assign tried_o  = r_tried;
  assign done_o   = r_done;
  assign busy_o   = (r_state == SETTLE) || (r_state == CHECK);
  assign found_o  = (r_state == FOUND);

endmodule

// File: tb/tb_csat_sweep_controller.sv
// tb_csat_sweep_controller
// Two instances: A (SETTLE_CYCLES=1) drives the multiplier-factorize style
// benchmark sat = assign[2:0]*assign[4:3]==15, B (SETTLE_CYCLES=3) sees sat
// tied low. A closed-form sweep model predicts every output each cycle.

module tb_csat_sweep_controller;

  localparam int M_IDLE  = 0;
  localparam int M_SWEEP = 1;
  localparam int M_FOUND = 2;
  localparam int M_EXH   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic       aStart, aResume, aAbort, aBusy, aDone, aFound, satA;
  logic [4:0] aAssign, aModel;
  logic [5:0] aTried;

  logic       bStart, bResume, bAbort, bBusy, bDone, bFound;
  logic [4:0] bAssign, bModel;
  logic [5:0] bTried;

  int total = 0;
  int bad   = 0;

  int mMode      [2];
  int mBase      [2];
  int mTriedBase [2];
  int mElapsed   [2];
  int mDec       [2];
  int mEnd       [2];
  int mAssign    [2];
  int mModel     [2];
  int mTried     [2];
  bit mDone      [2];
  bit mBusy      [2];
  bit mFound     [2];

  always #5 clk = ~clk;

  assign satA = ((int'(aAssign[2:0]) * int'(aAssign[4:3])) == 15);

  csat_sweep_controller #(.N_VARS(5), .SETTLE_CYCLES(1)) dutA (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (aStart),
    .resume_i (aResume),
    .abort_i  (aAbort),
    .assign_o (aAssign),
    .sat_i    (satA),
    .busy_o   (aBusy),
    .done_o   (aDone),
    .found_o  (aFound),
    .model_o  (aModel),
    .tried_o  (aTried)
  );

  csat_sweep_controller #(.N_VARS(5), .SETTLE_CYCLES(3)) dutB (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (bStart),
    .resume_i (bResume),
    .abort_i  (bAbort),
    .assign_o (bAssign),
    .sat_i    (1'b0),
    .busy_o   (bBusy),
    .done_o   (bDone),
    .found_o  (bFound),
    .model_o  (bModel),
    .tried_o  (bTried)
  );

  // Benchmark truth: instance 0 is the factorize circuit, instance 1 is unsat.
  function automatic bit benchSat(input int inst, input int a);
    if (inst != 0) return 1'b0;
    return ((a % 8) * (a / 8)) == 15;
  endfunction

  function automatic int settleOf(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // A sweep segment is fully determined by its first candidate: the deciding
  // candidate is the first satisfying one (or 31), reached after
  // (settle+1) cycles per candidate.
  task automatic beginSweep(input int inst, input int base, input int triedBase);
    int dec;
    dec = base;
    while (dec < 31 && !benchSat(inst, dec)) dec++;
    mMode[inst]      = M_SWEEP;
    mBase[inst]      = base;
    mTriedBase[inst] = triedBase;
    mElapsed[inst]   = 0;
    mDec[inst]       = dec;
    mEnd[inst]       = (settleOf(inst) + 1) * (dec - base + 1);
    mAssign[inst]    = base;
    mTried[inst]     = triedBase;
    mBusy[inst]      = 1'b1;
    mFound[inst]     = 1'b0;
  endtask

  task automatic stepModel(input int inst, input logic st, input logic rs, input logic ab);
    int per;
    int q;
    per = settleOf(inst) + 1;
    mDone[inst] = 1'b0;
    if (ab) begin
      mMode[inst]  = M_IDLE;
      mBusy[inst]  = 1'b0;
      mFound[inst] = 1'b0;
    end else if (st && mMode[inst] != M_SWEEP) begin
      mModel[inst] = 0;
      beginSweep(inst, 0, 0);
    end else if (mMode[inst] == M_SWEEP) begin
      mElapsed[inst]++;
      if (mElapsed[inst] == mEnd[inst]) begin
        mAssign[inst] = mDec[inst];
        mTried[inst]  = mTriedBase[inst] + mDec[inst] - mBase[inst] + 1;
        mBusy[inst]   = 1'b0;
        mDone[inst]   = 1'b1;
        if (benchSat(inst, mDec[inst])) begin
          mMode[inst]  = M_FOUND;
          mFound[inst] = 1'b1;
          mModel[inst] = mDec[inst];
        end else begin
          mMode[inst] = M_EXH;
        end
      end else begin
        q = mElapsed[inst] / per;
        mAssign[inst] = mBase[inst] + q;
        mTried[inst]  = mTriedBase[inst] + q;
      end
    end else if (rs && mMode[inst] == M_FOUND) begin
      if (mAssign[inst] == 31) begin
        mMode[inst]  = M_EXH;
        mFound[inst] = 1'b0;
        mDone[inst]  = 1'b1;
      end else begin
        beginSweep(inst, mAssign[inst] + 1, mTried[inst]);
      end
    end
  endtask

  // Reference model advances on the same edges the DUTs see.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mMode[i] = M_IDLE; mBase[i] = 0; mTriedBase[i] = 0; mElapsed[i] = 0;
        mDec[i] = 0; mEnd[i] = 0; mAssign[i] = 0; mModel[i] = 0; mTried[i] = 0;
        mDone[i] = 1'b0; mBusy[i] = 1'b0; mFound[i] = 1'b0;
      end
    end else begin
      stepModel(0, aStart, aResume, aAbort);
      stepModel(1, bStart, bResume, bAbort);
    end
  end

  // Every cycle, both instances are compared against the model.
  always @(negedge clk) begin
    checkOutput("A.assign", int'(aAssign), mAssign[0]);
    checkOutput("A.model",  int'(aModel),  mModel[0]);
    checkOutput("A.tried",  int'(aTried),  mTried[0]);
    checkOutput("A.busy",   int'(aBusy),   int'(mBusy[0]));
    checkOutput("A.done",   int'(aDone),   int'(mDone[0]));
    checkOutput("A.found",  int'(aFound),  int'(mFound[0]));
    checkOutput("B.assign", int'(bAssign), mAssign[1]);
    checkOutput("B.model",  int'(bModel),  mModel[1]);
    checkOutput("B.tried",  int'(bTried),  mTried[1]);
    checkOutput("B.busy",   int'(bBusy),   int'(mBusy[1]));
    checkOutput("B.done",   int'(bDone),   int'(mDone[1]));
    checkOutput("B.found",  int'(bFound),  int'(mFound[1]));
  end

  // Called at a falling edge: holds the inputs across exactly one rising edge.
  task automatic applyStimulus(input int inst, input logic st, input logic rs, input logic ab);
    if (inst == 0) begin
      aStart = st; aResume = rs; aAbort = ab;
    end else begin
      bStart = st; bResume = rs; bAbort = ab;
    end
    @(negedge clk);
    if (inst == 0) begin
      aStart = 1'b0; aResume = 1'b0; aAbort = 1'b0;
    end else begin
      bStart = 1'b0; bResume = 1'b0; bAbort = 1'b0;
    end
  endtask

  // Counts falling edges from the one right after the launching edge (=1).
  task automatic waitDone(input int inst, input int limit, output int cyc);
    cyc = 1;
    while (((inst == 0) ? aDone : bDone) == 1'b0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (((inst == 0) ? aDone : bDone) == 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL waitDone inst=%0d got=no done want=done within %0d", inst, limit);
    end
  endtask

  task automatic waitAssign(input int value, input int limit);
    int cnt;
    cnt = 0;
    while (int'(aAssign) != value && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    if (int'(aAssign) != value) begin
      total++;
      bad++;
      $display("[TB] FAIL waitAssign got=%0d want=%0d", aAssign, value);
    end
  endtask

  // Directed scenario sequence with hand-computed expectations.
  initial begin
    int cyc;
    aStart = 1'b0; aResume = 1'b0; aAbort = 1'b0;
    bStart = 1'b0; bResume = 1'b0; bAbort = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset.assign", int'(aAssign), 0);
    checkOutput("reset.model",  int'(aModel),  0);
    checkOutput("reset.tried",  int'(aTried),  0);
    checkOutput("reset.busy",   int'(aBusy),   0);
    checkOutput("reset.done",   int'(aDone),   0);
    checkOutput("reset.found",  int'(aFound),  0);

    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    checkOutput("startAbort.busy", int'(aBusy), 0);

    // 30 candidates (0..29) at 2 cycles each; the start cycle counts as 1.
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitDone(0, 200, cyc);
    checkOutput("single.latency", cyc, 61);
    checkOutput("single.found",   int'(aFound), 1);
    checkOutput("single.model",   int'(aModel), 29);
    checkOutput("single.tried",   int'(aTried), 30);

    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    waitDone(0, 50, cyc);
    checkOutput("resume.latency", cyc, 5);
    checkOutput("resume.found",   int'(aFound),  0);
    checkOutput("resume.model",   int'(aModel),  29);
    checkOutput("resume.tried",   int'(aTried),  32);
    checkOutput("resume.assign",  int'(aAssign), 31);

    // 32 candidates at 4 cycles each, start cycle counted as 1.
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    waitDone(1, 300, cyc);
    checkOutput("unsat.latency", cyc, 129);
    checkOutput("unsat.found",   int'(bFound),  0);
    checkOutput("unsat.tried",   int'(bTried),  32);
    checkOutput("unsat.assign",  int'(bAssign), 31);

    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitAssign(7, 100);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort.busy",   int'(aBusy),   0);
    checkOutput("abort.done",   int'(aDone),   0);
    checkOutput("abort.assign", int'(aAssign), 7);
    checkOutput("abort.found",  int'(aFound),  0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("restart.assign", int'(aAssign), 0);
    checkOutput("restart.tried",  int'(aTried),  0);
    checkOutput("restart.model",  int'(aModel),  0);
    checkOutput("restart.busy",   int'(aBusy),   1);

    waitAssign(3, 100);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("busyStart.assign", int'(aAssign), 3);
    checkOutput("busyStart.tried",  int'(aTried),  3);
    checkOutput("busyStart.busy",   int'(aBusy),   1);
    waitDone(0, 200, cyc);
    checkOutput("busyStart.model", int'(aModel), 29);

    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    checkOutput("startResume.assign", int'(aAssign), 0);
    checkOutput("startResume.tried",  int'(aTried),  0);
    checkOutput("startResume.model",  int'(aModel),  0);
    checkOutput("startResume.busy",   int'(aBusy),   1);
    checkOutput("startResume.found",  int'(aFound),  0);

    waitAssign(12, 100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset.assign", int'(aAssign), 0);
    checkOutput("asyncReset.model",  int'(aModel),  0);
    checkOutput("asyncReset.tried",  int'(aTried),  0);
    checkOutput("asyncReset.busy",   int'(aBusy),   0);
    checkOutput("asyncReset.done",   int'(aDone),   0);
    checkOutput("asyncReset.found",  int'(aFound),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitDone(0, 200, cyc);
    checkOutput("afterReset.latency", cyc, 61);
    checkOutput("afterReset.model",   int'(aModel), 29);
    checkOutput("afterReset.tried",   int'(aTried), 30);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
